fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 npc_sel  in  2  redirect request from EX branch unit: 00 sequential, 01 branch taken, 10 jump (jal/jalr), 11 treated as 00.
REQ-005 br_target  in  32  branch target (EX pc + imm).
REQ-006 jmp_target  in  32  jump target (ALU result).
REQ-007 stall_if  in  1  ID not accepting; hold IF/ID output.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address.
REQ-010 imem_ready  in  1  response strobe; imem_rdata valid this cycle.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 pc_if / inst_if  out  32 / 32  PC and instruction presented to ID.
REQ-013 inst_valid  out  1  pc_if/inst_if hold a live instruction.
REQ-014 flush_id / flush_ex  out  1 / 1  kill IF/ID and ID/EX contents.

Function
REQ-015 redirect = npc_sel in {01,10}; target = br_target (01) or jmp_target (10), bits [1:0] forced to 00.
REQ-016 flush_id and flush_ex SHALL equal redirect combinationally, same cycle, regardless of stall_if.
REQ-017 FSM states: FETCH, HOLD, DRAIN.
REQ-018 FETCH: imem_req = 1 when output slot free or being consumed (!inst_valid or !stall_if), or when a request is already outstanding; imem_addr = pc.
REQ-019 An asserted request SHALL keep imem_req high and imem_addr stable until imem_ready.
REQ-020 FETCH, imem_ready, no redirect, slot free/consumed: load pc_if<=pc, inst_if<=imem_rdata, inst_valid<=1, pc<=pc+4 (mod 2^32); 1-cycle latency from imem_ready to inst_valid.
REQ-021 FETCH, imem_ready, no redirect, slot full and stall_if=1: store response in skid entry, pc<=pc+4, go HOLD.
REQ-022 HOLD: imem_req=0; when stall_if=0, skid moves to output, go FETCH.
REQ-023 Output with inst_valid=1 and stall_if=1 SHALL hold unchanged.
REQ-024 No stall, no new response: inst_valid<=0 after consumption.
REQ-025 Redirect (priority over all): inst_valid<=0, skid cleared, pc<=target.
REQ-026 Redirect with request outstanding and no imem_ready that cycle: go DRAIN; keep req/addr stable, discard data on imem_ready, then FETCH from target.
REQ-027 Redirect with imem_ready same cycle: discard data, FETCH from target next cycle, no DRAIN.
REQ-028 Redirect in DRAIN: update pc to new target, stay DRAIN.
REQ-029 Redirect in HOLD: clear skid, go FETCH.

Reset
REQ-030 rst_n=0: pc=RESET_PC, state=FETCH, inst_valid=0, pc_if=0, inst_if=0, skid empty, imem_req=0.
REQ-031 First rising edge after release: imem_req=1, imem_addr=RESET_PC.
REQ-032 Reset mid-request SHALL abandon the request; no response is expected.

Structure
REQ-033 Package cpu_pkg: npc_sel encodings NPC_SEQ/NPC_BR/NPC_JMP, RESET_PC default, FSM state typedef.
REQ-034 One sub-module: fetch_skid (one-entry pc+instruction buffer with valid).

Verification
REQ-035 Reset release, imem_ready every cycle, no stall -> pc_if 0x00400000, 0x00400004, 0x00400008 on consecutive cycles, inst_valid=1 from 2nd cycle.
REQ-036 stall_if=1 for 3 cycles with 1 response arriving -> output frozen, skid holds next word, imem_req=0 in HOLD; release -> skid word out next cycle.
REQ-037 npc_sel=01, br_target=0x00400100, imem_ready=1 same cycle -> flush_id=flush_ex=1, inst_valid=0 next cycle, next imem_addr=0x00400100.
REQ-038 npc_sel=10, jmp_target=0x00400203 during outstanding request, imem_ready 2 cycles later -> DRAIN, response discarded, then imem_addr=0x00400200.
REQ-039 pc=0xFFFFFFFC fetch -> next imem_addr 0x00000000.
REQ-040 rst_n low mid-DRAIN -> imem_req=0, inst_valid=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: redirect encodings,
// reset vector and the fetch FSM state type.
package cpu_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_RSV = 2'b11;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fstate_e;

    function automatic logic [31:0] align4(
        input logic [31:0] a
    );
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched pc/instruction
// while the IF/ID slot is stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    // Capture on load; clear wins so a flush empties the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: pc sequencing, redirect
// handling, imem handshake and IF/ID output slot.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic        stall_if,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] inst_if,
    output logic        inst_valid,
    output logic        flush_id,
    output logic        flush_ex
);

    fstate_e     state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] inst_if_q, inst_if_d;
    logic        valid_q, valid_d;
    logic        alive_q;

    logic        redirect;
    logic [31:0] target;
    logic        rsp;
    logic        slot_free;
    logic        skid_load;
    logic        skid_clear;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    assign redirect = (npc_sel != NPC_SEQ)
                   && (npc_sel != NPC_RSV);
    assign target   = align4((npc_sel == NPC_JMP)
                    ? jmp_target : br_target);
    assign flush_id = redirect;
    assign flush_ex = redirect;

    // alive_q keeps the request low until the first edge
    // after reset release.
    assign imem_req  = alive_q && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? daddr_q : pc_q;
    assign rsp       = imem_req && imem_ready;
    assign slot_free = !valid_q || !stall_if;

    assign pc_if      = pc_if_q;
    assign inst_if    = inst_if_q;
    assign inst_valid = valid_q;

    fetch_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .inst_i  (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    // State, pc and IF/ID slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            daddr_q   <= '0;
            pc_if_q   <= '0;
            inst_if_q <= '0;
            valid_q   <= 1'b0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            daddr_q   <= daddr_d;
            pc_if_q   <= pc_if_d;
            inst_if_q <= inst_if_d;
            valid_q   <= valid_d;
            alive_q   <= 1'b1;
        end
    end

    // Next state: redirect first, then per-state fetch flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        daddr_d    = daddr_q;
        pc_if_d    = pc_if_q;
        inst_if_d  = inst_if_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            pc_d       = target;
            if (imem_req && !imem_ready) begin
                state_d = DRAIN;
                if (state_q == FETCH) begin
                    daddr_d = pc_q;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (rsp && slot_free) begin
                        pc_if_d   = pc_q;
                        inst_if_d = imem_rdata;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end else if (rsp) begin
                        skid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = HOLD;
                    end else if (!stall_if) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_if) begin
                        pc_if_d    = skid_pc;
                        inst_if_d  = skid_inst;
                        valid_d    = skid_valid;
                        skid_clear = 1'b1;
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (!stall_if) begin
                        valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: delivered pc/inst pairs
// are checked against a queue filled by a small fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RP = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  npc_sel;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        stall_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] inst_if;
    logic        inst_valid;
    logic        flush_id;
    logic        flush_ex;

    int tests = 0;
    int fails = 0;

    logic [63:0] sbq[$];
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    bit          m_drain;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(
        input logic [31:0] a
    );
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = imem_ready ? inst_of(imem_addr)
                                   : 32'hDEAD_BEEF;

    fetch_ctrl #(.RESET_PC(RP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_sel    (npc_sel),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .stall_if   (stall_if),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_if      (pc_if),
        .inst_if    (inst_if),
        .inst_valid (inst_valid),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex)
    );

    function automatic logic [31:0] exp_addr();
        return m_drain ? m_daddr : m_pc;
    endfunction

    task automatic set_in(
        input bit          s,
        input bit          r,
        input logic [1:0]  sel,
        input logic [31:0] b,
        input logic [31:0] j
    );
        stall_if   = s;
        imem_ready = r;
        npc_sel    = sel;
        br_target  = b;
        jmp_target = j;
    endtask

    // Model update from this cycle's inputs, then step.
    task automatic adv();
        logic        redir;
        logic [31:0] tgt;
        redir = (npc_sel == 2'b01) || (npc_sel == 2'b10);
        tgt   = (npc_sel == 2'b10) ? jmp_target : br_target;
        tgt[1:0] = 2'b00;
        if (redir) begin
            if (!imem_ready) begin
                if (!m_drain) m_daddr = m_pc;
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
            end
            m_pc = tgt;
        end else if (m_drain) begin
            if (imem_ready) m_drain = 1'b0;
        end else if (imem_ready) begin
            sbq.push_back({m_pc, inst_of(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 2'b00, '0, '0);
        m_pc = RP;
        m_drain = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_req got %b want 0", imem_req);
        end
        tests++;
        if (inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid got %b want 0",
                     inst_valid);
        end
        tests++;
        if ({pc_if, inst_if} !== 64'h0) begin
            fails++;
            $display("FAIL rst_out got %h %h want 0",
                     pc_if, inst_if);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rel_req got %b want 0", imem_req);
        end
        @(posedge clk);
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== RP) begin
            fails++;
            $display("FAIL first_req got %b %h want 1 %h",
                     imem_req, imem_addr, RP);
        end
    endtask

    task automatic test_stream();
        logic [63:0] e;
        for (int k = 0; k < 6; k++) begin
            set_in(0, 1, 2'b00, '0, '0);
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1
                || imem_addr !== exp_addr()) begin
                fails++;
                $display("FAIL stream_addr got %b %h want 1 %h",
                         imem_req, imem_addr, exp_addr());
            end
            tests++;
            if (inst_valid !== (k != 0)) begin
                fails++;
                $display("FAIL stream_valid k=%0d got %b",
                         k, inst_valid);
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL stream_pop extra pc %h",
                             pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL stream_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    task automatic test_stall();
        logic [63:0] e;
        bit st[5] = '{1, 1, 1, 0, 0};
        bit rd[5] = '{1, 0, 0, 0, 0};
        for (int k = 0; k < 5; k++) begin
            set_in(st[k], rd[k], 2'b00, '0, '0);
            @(negedge clk);
            tests++;
            if (imem_req !== (k == 0 || k == 4)) begin
                fails++;
                $display("FAIL stall_req k=%0d got %b",
                         k, imem_req);
            end
            if (k >= 1 && k <= 3) begin
                tests++;
                if (sbq.size() == 0 || inst_valid !== 1'b1
                    || {pc_if, inst_if} !== sbq[0]) begin
                    fails++;
                    $display("FAIL stall_frozen k=%0d got %b %h",
                             k, inst_valid, pc_if);
                end
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL stall_pop extra pc %h",
                             pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL stall_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    task automatic test_branch();
        logic [63:0] e;
        logic [1:0]  sel;
        for (int k = 0; k < 6; k++) begin
            sel = (k == 0) ? 2'b01 : 2'b11;
            set_in(0, k < 5, sel, 32'h0040_0100, '0);
            @(negedge clk);
            tests++;
            if (flush_id !== (k == 0)
                || flush_ex !== (k == 0)) begin
                fails++;
                $display("FAIL br_flush k=%0d got %b %b",
                         k, flush_id, flush_ex);
            end
            if (k == 1) begin
                tests++;
                if (inst_valid !== 1'b0
                    || imem_addr !== 32'h0040_0100) begin
                    fails++;
                    $display("FAIL br_next got %b %h want 0 00400100",
                             inst_valid, imem_addr);
                end
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL br_pop extra pc %h", pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL br_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    task automatic test_drain();
        logic [63:0] e;
        logic [1:0]  sl[9] = '{2'b10, 2'b00, 2'b00, 2'b00,
                               2'b00, 2'b10, 2'b01, 2'b00,
                               2'b00};
        bit          rd[9] = '{0, 0, 1, 1, 0, 0, 0, 1, 0};
        logic [31:0] jt;
        for (int k = 0; k < 9; k++) begin
            jt = (k < 5) ? 32'h0040_0203 : 32'h0040_0400;
            set_in(0, rd[k], sl[k], 32'h0040_0300, jt);
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1
                || imem_addr !== exp_addr()) begin
                fails++;
                $display("FAIL drain_addr k=%0d got %b %h want 1 %h",
                         k, imem_req, imem_addr, exp_addr());
            end
            tests++;
            if (flush_id !== (sl[k] != 2'b00)) begin
                fails++;
                $display("FAIL drain_flush k=%0d got %b",
                         k, flush_id);
            end
            if (k == 3) begin
                tests++;
                if (imem_addr !== 32'h0040_0200) begin
                    fails++;
                    $display("FAIL jmp_target got %h want 00400200",
                             imem_addr);
                end
            end
            if (k == 2 || k == 3 || k == 8) begin
                tests++;
                if (inst_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL drain_discard k=%0d got %b",
                             k, inst_valid);
                end
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL drain_pop extra pc %h", pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL drain_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        for (int k = 0; k < 4; k++) begin
            set_in(0, k < 2, (k == 0) ? 2'b10 : 2'b00,
                   '0, 32'hFFFF_FFFC);
            @(negedge clk);
            tests++;
            if (imem_addr !== exp_addr()) begin
                fails++;
                $display("FAIL wrap_addr k=%0d got %h want %h",
                         k, imem_addr, exp_addr());
            end
            if (k == 2) begin
                tests++;
                if (imem_addr !== 32'h0) begin
                    fails++;
                    $display("FAIL wrap_zero got %h want 0",
                             imem_addr);
                end
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL wrap_pop extra pc %h", pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL wrap_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_drain();
        logic [63:0] e;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL lost_out got %0d queued want 0",
                     sbq.size());
        end
        set_in(0, 0, 2'b10, '0, 32'h0040_0500);
        @(negedge clk);
        adv();
        set_in(0, 0, 2'b00, '0, '0);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== m_daddr) begin
            fails++;
            $display("FAIL rd_drain got %b %h want 1 %h",
                     imem_req, imem_addr, m_daddr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL rd_async got %b %b want 0 0",
                     imem_req, inst_valid);
        end
        sbq.delete();
        m_pc = RP;
        m_drain = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 2'b00, '0, '0);
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1
                || imem_addr !== exp_addr()) begin
                fails++;
                $display("FAIL rd_restart k=%0d got %b %h want 1 %h",
                         k, imem_req, imem_addr, exp_addr());
            end
            if (inst_valid && !stall_if) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL rd_pop extra pc %h", pc_if);
                end else begin
                    e = sbq.pop_front();
                    if ({pc_if, inst_if} !== e) begin
                        fails++;
                        $display("FAIL rd_pop got %h %h want %h",
                                 pc_if, inst_if, e);
                    end
                end
            end
            adv();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_drain();
        test_wrap();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
